// File: rtl/mem_responder_if.sv
// ============================================================================
// Module   : mem_responder_if
// Purpose  : CPU strobe bus and host preload bus between controller and memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    // CPU side
    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic              i_wr;
    logic [DATA_W-1:0] i_data_in;
    logic [DATA_W-1:0] o_data_out;
    logic              o_data_oe;
    logic              o_rdy;
    logic              o_err;

    // Host preload side
    logic              i_prog_en;
    logic              i_prog_we;
    logic [ADDR_W-1:0] i_prog_addr;
    logic [DATA_W-1:0] i_prog_data;

    modport slave (
        input  i_addr, i_rd, i_wr, i_data_in,
        input  i_prog_en, i_prog_we, i_prog_addr, i_prog_data,
        output o_data_out, o_data_oe, o_rdy, o_err
    );

    modport master (
        output i_addr, i_rd, i_wr, i_data_in,
        output i_prog_en, i_prog_we, i_prog_addr, i_prog_data,
        input  o_data_out, o_data_oe, o_rdy, o_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : RAM target for a multicycle CPU: latency-programmable reads,
//            single-shot writes per wr pulse, and a host preload port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_responder_if.slave   io_bus
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] c_CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [1:0]        r_cnt;
    logic              r_wr_q;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rdy;
    logic              r_data_oe;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_cpu_live;
    logic              w_conflict;
    logic              w_cpu_we;
    logic              w_addr_moved;
    logic              w_new_read;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_q_word;

    // The host owns the RAM while prog_en is high; every CPU decision is gated by it.
    assign w_cpu_live   = ~io_bus.i_prog_en;
    assign w_conflict   = w_cpu_live & io_bus.i_rd & io_bus.i_wr;
    assign w_cpu_we     = w_cpu_live & io_bus.i_wr & ~r_wr_q & ~io_bus.i_rd;
    assign w_addr_moved = (io_bus.i_addr != r_addr_q);
    assign w_new_read   = w_cpu_live & ~w_conflict & io_bus.i_rd &
                          ((r_state == ST_IDLE) |
                           ((r_state == ST_RD_DRIVE) & w_addr_moved));

    assign w_rd_word = r_mem[io_bus.i_addr];
    assign w_q_word  = r_mem[r_addr_q];

    // RAM contents survive reset, so the array lives in its own reset-less process.
    always_ff @(posedge clk) begin
        if (io_bus.i_prog_en) begin
            if (io_bus.i_prog_we) begin
                r_mem[io_bus.i_prog_addr] <= io_bus.i_prog_data;
            end
        end else if (w_cpu_we) begin
            r_mem[io_bus.i_addr] <= io_bus.i_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr_q   <= '0;
            r_cnt      <= 2'd0;
            r_wr_q     <= 1'b0;
            r_data_out <= '0;
            r_rdy      <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Tracked even under prog_en so a wr held across release is not replayed.
            r_wr_q <= io_bus.i_wr;

            if (!w_cpu_live) begin
                r_state   <= ST_IDLE;
                r_rdy     <= 1'b0;
                r_data_oe <= 1'b0;
            end else if (w_conflict) begin
                r_err     <= 1'b1;
                r_state   <= ST_IDLE;
                r_rdy     <= 1'b0;
                r_data_oe <= 1'b0;
            end else if (w_new_read) begin
                r_addr_q <= io_bus.i_addr;
                if (RD_LAT == 0) begin
                    r_data_out <= w_rd_word;
                    r_state    <= ST_RD_DRIVE;
                    r_rdy      <= 1'b1;
                    r_data_oe  <= 1'b1;
                end else begin
                    r_cnt     <= c_CNT_INIT;
                    r_state   <= ST_RD_WAIT;
                    r_rdy     <= 1'b0;
                    r_data_oe <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_RD_WAIT: begin
                        if (!io_bus.i_rd) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt == 2'd0) begin
                            r_data_out <= w_q_word;
                            r_state    <= ST_RD_DRIVE;
                            r_rdy      <= 1'b1;
                            r_data_oe  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 2'd1;
                        end
                    end
                    ST_RD_DRIVE: begin
                        // Same address with rd held: keep driving; a new address was handled above.
                        if (!io_bus.i_rd) begin
                            r_state   <= ST_IDLE;
                            r_rdy     <= 1'b0;
                            r_data_oe <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_rdy     <= 1'b0;
                        r_data_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.o_data_out = r_data_out;
    assign io_bus.o_data_oe  = r_data_oe;
    assign io_bus.o_rdy      = r_rdy;
    assign io_bus.o_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench; three responders (RD_LAT 0/1/2) share one
//            stimulus stream and are checked against a word-array model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] data_in;
    logic       prog_en;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] mem_m    [32];
    logic [7:0] last_out [3];
    logic       err_m;

    logic [7:0] dout [3];
    logic       rdy  [3];
    logic       oe   [3];
    logic       err  [3];

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(5), .DATA_W(8)) if0 ();
    mem_responder_if #(.ADDR_W(5), .DATA_W(8)) if1 ();
    mem_responder_if #(.ADDR_W(5), .DATA_W(8)) if2 ();

    assign if0.i_addr = addr;  assign if1.i_addr = addr;  assign if2.i_addr = addr;
    assign if0.i_rd   = rd;    assign if1.i_rd   = rd;    assign if2.i_rd   = rd;
    assign if0.i_wr   = wr;    assign if1.i_wr   = wr;    assign if2.i_wr   = wr;
    assign if0.i_data_in   = data_in;   assign if1.i_data_in   = data_in;   assign if2.i_data_in   = data_in;
    assign if0.i_prog_en   = prog_en;   assign if1.i_prog_en   = prog_en;   assign if2.i_prog_en   = prog_en;
    assign if0.i_prog_we   = prog_we;   assign if1.i_prog_we   = prog_we;   assign if2.i_prog_we   = prog_we;
    assign if0.i_prog_addr = prog_addr; assign if1.i_prog_addr = prog_addr; assign if2.i_prog_addr = prog_addr;
    assign if0.i_prog_data = prog_data; assign if1.i_prog_data = prog_data; assign if2.i_prog_data = prog_data;

    assign dout[0] = if0.o_data_out; assign rdy[0] = if0.o_rdy; assign oe[0] = if0.o_data_oe; assign err[0] = if0.o_err;
    assign dout[1] = if1.o_data_out; assign rdy[1] = if1.o_rdy; assign oe[1] = if1.o_data_oe; assign err[1] = if1.o_err;
    assign dout[2] = if2.o_data_out; assign rdy[2] = if2.o_rdy; assign oe[2] = if2.o_data_oe; assign err[2] = if2.o_err;

    mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_bus(if0.slave));
    mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(if1.slave));
    mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_bus(if2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[lat%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_rdy"}, k, 32'(rdy[k]), 32'd0);
            check({tag, "_oe"},  k, 32'(oe[k]),  32'd0);
            check({tag, "_err"}, k, 32'(err[k]), 32'(err_m));
        end
    endtask

    // Drives rd for three edges; instance k must present mem[a] from edge T+k on.
    task automatic read_seq(input logic [4:0] a);
        addr = a;
        rd   = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (j >= k) begin
                    check("rd_rdy",  k, 32'(rdy[k]),  32'd1);
                    check("rd_oe",   k, 32'(oe[k]),   32'd1);
                    check("rd_data", k, 32'(dout[k]), 32'(mem_m[a]));
                    last_out[k] = mem_m[a];
                end else begin
                    check("rd_wait_rdy", k, 32'(rdy[k]), 32'd0);
                    check("rd_wait_oe",  k, 32'(oe[k]),  32'd0);
                end
            end
        end
    endtask

    task automatic end_read();
        rd = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check("drop_rdy",  k, 32'(rdy[k]),  32'd0);
            check("drop_oe",   k, 32'(oe[k]),   32'd0);
            check("drop_data", k, 32'(dout[k]), 32'(last_out[k]));
        end
    endtask

    task automatic write_op(input logic [4:0] a, input logic [7:0] d, input bit hold2, input logic [7:0] d2);
        addr    = a;
        data_in = d;
        wr      = 1'b1;
        step();
        if (hold2) begin
            data_in = d2;
            step();
        end
        wr = 1'b0;
        step();
        mem_m[a] = d;
        check_quiet("wr");
    endtask

    initial begin
        logic [7:0] init_words [4];
        logic [4:0] ra;
        logic [4:0] rb;
        init_words = '{8'hA3, 8'h1F, 8'h00, 8'hE5};

        rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        err_m = 1'b0;
        for (int k = 0; k < 3; k++) last_out[k] = 8'h00;

        step();
        step();
        for (int k = 0; k < 3; k++) check("reset_data", k, 32'(dout[k]), 32'd0);
        check_quiet("reset");
        rst_n = 1'b1;
        step();

        // Preload every word; CPU strobes (including a conflict and a held wr) must be ignored.
        prog_en = 1'b1;
        rd = 1'b1; wr = 1'b1; addr = 5'd7; data_in = 8'h99;
        for (int i = 0; i < 32; i++) begin
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = (i < 4) ? init_words[i] : 8'($urandom);
            mem_m[i]  = prog_data;
            step();
        end
        check_quiet("prog");
        rd = 1'b0; prog_we = 1'b0; prog_en = 1'b0;
        step();
        wr = 1'b0;
        step();
        check_quiet("release");

        read_seq(5'd1); end_read();
        read_seq(5'd3); end_read();
        read_seq(5'd7); end_read();

        write_op(5'd5, 8'h5A, 1'b1, 8'hC3);
        read_seq(5'd5); end_read();

        addr = 5'd2; data_in = 8'hFF; rd = 1'b1; wr = 1'b1;
        step();
        err_m = 1'b1;
        check_quiet("conflict");
        rd = 1'b0; wr = 1'b0;
        step();
        check_quiet("conflict_sticky");
        read_seq(5'd2); end_read();

        read_seq(5'd0); read_seq(5'd1); end_read();

        repeat (24) begin
            case ($urandom_range(0, 2))
                0: write_op(5'($urandom_range(4, 31)), 8'($urandom), 1'($urandom), 8'($urandom));
                1: begin read_seq(5'($urandom)); end_read(); end
                default: begin
                    ra = 5'($urandom);
                    rb = ra + 5'($urandom_range(1, 31));
                    read_seq(ra); read_seq(rb); end_read();
                end
            endcase
        end

        // Asynchronous reset while the latent instances sit in their wait state.
        addr = 5'd3; rd = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        err_m = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("arst_data", k, 32'(dout[k]), 32'd0);
            last_out[k] = 8'h00;
        end
        check_quiet("arst");
        rd = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_quiet("post_arst");
        read_seq(5'd0); end_read();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
